// File: rtl/adder_arb_pkg.sv
// rtl/adder_arb_pkg.sv - shared defaults and FSM state encoding for adder_arbiter
package adder_arb_pkg;

    localparam int WIDTH_DEF   = 8;
    localparam int NUM_REQ_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_EXEC  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/adder_arbiter_if.sv
// rtl/adder_arbiter_if.sv - requester-side bundle of the shared adder arbiter
interface adder_arbiter_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] a_in;
    logic [NUM_REQ*WIDTH-1:0] b_in;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [NUM_REQ-1:0]       rsp_ready;
    logic [WIDTH-1:0]         sum_out;
    logic                     busy;

    modport master (
        output req, a_in, b_in, rsp_ready,
        input  gnt, rsp_valid, sum_out, busy
    );

    modport slave (
        input  req, a_in, b_in, rsp_ready,
        output gnt, rsp_valid, sum_out, busy
    );
endinterface

// File: rtl/adder.sv
// rtl/adder.sv - unsigned modular adder, carry out discarded
module adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sharing one adder between requesters
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] a_in,
    input  logic [NUM_REQ*WIDTH-1:0] b_in,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]         sum_out,
    output logic                     busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] S_GRANT = 2'(ST_GRANT);
    localparam logic [1:0] S_EXEC  = 2'(ST_EXEC);
    localparam logic [1:0] S_RESP  = 2'(ST_RESP);

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win_q, win_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] add_sum;

    logic [PTR_W-1:0] pick_idx;
    logic             pick_found;
    int               rr_idx;

    adder #(.WIDTH(WIDTH)) u_adder (
        .a_i   (a_q),
        .b_i   (b_q),
        .sum_o (add_sum)
    );

    // First asserted request at or above ptr, wrapping modulo NUM_REQ.
    always_comb begin
        pick_idx   = ptr_q;
        pick_found = 1'b0;
        rr_idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!pick_found && req[rr_idx]) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'(rr_idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    win_d   = pick_idx;
                    a_d     = a_in[pick_idx*WIDTH +: WIDTH];
                    b_d     = b_in[pick_idx*WIDTH +: WIDTH];
                    state_d = S_GRANT;
                end
            end
            S_GRANT: state_d = S_EXEC;
            S_EXEC: begin
                sum_d   = add_sum;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready[win_q]) begin
                    state_d = S_IDLE;
                    ptr_d   = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + PTR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        gnt       = '0;
        rsp_valid = '0;
        sum_out   = '0;
        if (state_q == S_GRANT) begin
            gnt[win_q] = 1'b1;
        end
        if (state_q == S_RESP) begin
            rsp_valid[win_q] = 1'b1;
            sum_out          = sum_q;
        end
    end

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - randomized self-checking bench for adder_arbiter
module tb_adder_arbiter;
    import adder_arb_pkg::*;

    localparam int W = 8;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    int   m_ptr = 0;

    adder_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

    adder_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus.req),
        .a_in      (bus.a_in),
        .b_in      (bus.b_in),
        .gnt       (bus.gnt),
        .rsp_valid (bus.rsp_valid),
        .rsp_ready (bus.rsp_ready),
        .sum_out   (bus.sum_out),
        .busy      (bus.busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] rq, input int p);
        for (int k = 0; k < N; k++) begin
            if (rq[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Entered and left at a falling edge with the DUT idle.
    task automatic run_txn(input logic [N-1:0] rq, input logic [N*W-1:0] av,
                           input logic [N*W-1:0] bv, input int delay,
                           input logic [N-1:0] stray);
        int           w;
        logic [N-1:0] oh;
        logic [W-1:0] exp_sum;
        bus.req       = rq;
        bus.a_in      = av;
        bus.b_in      = bv;
        bus.rsp_ready = '0;
        w       = pick(rq, m_ptr);
        oh      = N'(1) << w;
        exp_sum = W'((32'(av[w*W +: W]) + 32'(bv[w*W +: W])) % 256);
        @(negedge clk);
        check("grant_onehot", 32'(bus.gnt), 32'(oh));
        check("grant_no_rsp", 32'(bus.rsp_valid), 0);
        check("grant_busy", 32'(bus.busy), 1);
        bus.a_in = {$urandom, $urandom};
        bus.b_in = {$urandom, $urandom};
        bus.req  = N'($urandom);
        @(negedge clk);
        check("exec_no_gnt", 32'(bus.gnt), 0);
        check("exec_no_rsp", 32'(bus.rsp_valid), 0);
        check("exec_sum_zero", 32'(bus.sum_out), 0);
        @(negedge clk);
        check("resp_valid", 32'(bus.rsp_valid), 32'(oh));
        check("resp_sum", 32'(bus.sum_out), 32'(exp_sum));
        bus.rsp_ready = stray & ~oh;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.rsp_valid), 32'(oh));
            check("hold_sum", 32'(bus.sum_out), 32'(exp_sum));
            check("hold_no_gnt", 32'(bus.gnt), 0);
            check("hold_busy", 32'(bus.busy), 1);
            bus.req = N'($urandom);
        end
        bus.rsp_ready = oh | stray;
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 0);
        check("idle_no_rsp", 32'(bus.rsp_valid), 0);
        check("idle_sum_zero", 32'(bus.sum_out), 0);
        bus.rsp_ready = '0;
        m_ptr = (w + 1) % N;
    endtask

    initial begin
        logic [N*W-1:0] av, bv;
        logic [N-1:0]   rq;
        rst_n         = 1'b0;
        bus.req       = '0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.rsp_ready = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(bus.gnt), 0);
        check("rst_rsp", 32'(bus.rsp_valid), 0);
        check("rst_sum", 32'(bus.sum_out), 0);
        check("rst_busy", 32'(bus.busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_stays", 32'(bus.busy), 0);

        // Single request, 20 + 22.
        av = {$urandom, $urandom};
        bv = {$urandom, $urandom};
        av[7:0] = 8'd20;
        bv[7:0] = 8'd22;
        run_txn(4'b0001, av, bv, 2, 4'b0000);

        // Wrap on requester 2.
        av = {$urandom, $urandom};
        bv = {$urandom, $urandom};
        av[23:16] = 8'hF0;
        bv[23:16] = 8'h20;
        run_txn(4'b0100, av, bv, 0, 4'b0000);

        // All requesting, immediate acceptance.
        for (int t = 0; t < 5; t++) begin
            run_txn(4'b1111, {$urandom, $urandom}, {$urandom, $urandom}, 0, 4'b0000);
        end

        // Backpressure with competing requests.
        run_txn(4'b1111, {$urandom, $urandom}, {$urandom, $urandom}, 5, 4'b0000);
        run_txn(4'b1111, {$urandom, $urandom}, {$urandom, $urandom}, 0, 4'b0000);

        // Stray acceptance from non-winners while requester 3 waits.
        run_txn(4'b1000, {$urandom, $urandom}, {$urandom, $urandom}, 4, 4'b0111);

        // Reset mid-EXEC after moving the pointer to 2.
        run_txn(4'b0010, {$urandom, $urandom}, {$urandom, $urandom}, 0, 4'b0000);
        bus.req = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_gnt", 32'(bus.gnt), 0);
        check("mid_rst_rsp", 32'(bus.rsp_valid), 0);
        check("mid_rst_sum", 32'(bus.sum_out), 0);
        check("mid_rst_busy", 32'(bus.busy), 0);
        rst_n   = 1'b1;
        bus.req = '0;
        m_ptr   = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abandoned_rsp", 32'(bus.rsp_valid), 0);
            check("abandoned_busy", 32'(bus.busy), 0);
        end
        run_txn(4'b1010, {$urandom, $urandom}, {$urandom, $urandom}, 0, 4'b0000);

        // Random traffic with occasional idle cycles.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.req = '0;
                @(negedge clk);
                check("rand_idle_busy", 32'(bus.busy), 0);
            end
            rq = N'($urandom_range(1, 15));
            run_txn(rq, {$urandom, $urandom}, {$urandom, $urandom},
                    $urandom_range(0, 3), N'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
